// File: rtl/lcd_ram_scanner_if.sv
// RAM read-port and LCD pin bundle for the LCD RAM scanner.
// The scanner is the master: it drives the RAM address and the LCD pins,
// and it consumes the RAM write-enable and read data.
interface lcd_ram_scanner_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12
);
  logic                     ramWEn;
  logic [ADDRESS_WIDTH-1:0] lcdOutAddr;
  logic [DATA_WIDTH-1:0]    lcdDataOut;
  logic                     lcd_rs;
  logic                     lcd_rw;
  logic                     lcd_e;
  logic [7:0]               lcd_data;
  logic                     frame_done;

  modport master (
    input  ramWEn, lcdDataOut,
    output lcdOutAddr, lcd_rs, lcd_rw, lcd_e, lcd_data, frame_done
  );

  modport slave (
    output ramWEn, lcdDataOut,
    input  lcdOutAddr, lcd_rs, lcd_rw, lcd_e, lcd_data, frame_done
  );
endinterface

// File: rtl/lcd_ram_scanner.sv
// Mirrors a 2x16 character window of the data RAM onto an HD44780 panel
// (8-bit, write-only, open-loop timing). Power-on init runs once, then the
// whole screen is refreshed forever.
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_PWR_WAIT | power-up settle delay before the first command
// S_INIT     | pick the next of the four init commands, start a transfer
// S_SET_LINE | send DDRAM address 0x80 (line 0) or 0xC0 (line 1)
// S_FETCH    | RAM address held; retry while the RAM is being written
// S_LATCH    | RAM read data valid; sanitize and start a data transfer
// S_XFER     | setup / E high / hold / post-command delay
// S_NEXT     | advance char index, choose line switch or frame wrap
module lcd_ram_scanner #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12,
  parameter int LCD_BASE      = 3840,
  parameter int CLKS_PER_US   = 50,
  parameter int E_HIGH        = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  lcd_ram_scanner_if.master bus
);

  typedef enum logic [2:0] {
    S_PWR_WAIT, S_INIT, S_SET_LINE, S_FETCH, S_LATCH, S_XFER, S_NEXT
  } state_t;

  typedef enum logic [1:0] {PH_SETUP, PH_EHIGH, PH_HOLD, PH_WAIT} phase_t;

  // What to do once a transfer's delay expires.
  typedef enum logic [1:0] {K_INIT, K_LINE, K_DATA} kind_t;

  localparam logic [23:0] DLY_PWR = 24'(15000 * CLKS_PER_US - 1);
  localparam logic [23:0] DLY_CLR = 24'(1640 * CLKS_PER_US - 1);
  localparam logic [23:0] DLY_STD = 24'(40 * CLKS_PER_US - 1);
  localparam logic [23:0] DLY_EHI = 24'(E_HIGH - 1);
  localparam logic [ADDRESS_WIDTH-1:0] BASE_A = ADDRESS_WIDTH'(LCD_BASE);

  state_t                   state_q, state_d;
  phase_t                   phase_q, phase_d;
  kind_t                    kind_q, kind_d;
  logic [23:0]              dly_q, dly_d;
  logic                     armed_q, armed_d;
  logic [1:0]               init_idx_q, init_idx_d;
  logic [4:0]               idx_q, idx_d;
  logic                     rs_q, rs_d;
  logic [7:0]               data_q, data_d;
  logic                     e_q, e_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic                     fd_q, fd_d;

  // Only the low byte of a RAM word carries the character.
  logic unused_hi;
  assign unused_hi = ^bus.lcdDataOut[DATA_WIDTH-1:8];

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  // Non-printable codes would show CGRAM/garbage glyphs; show a blank instead.
  function automatic logic [7:0] sanitize(input logic [7:0] b);
    return (b >= 8'h20 && b <= 8'h7E) ? b : 8'h20;
  endfunction

  // State and output registers; reset drops lcd_e immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_PWR_WAIT;
      phase_q    <= PH_SETUP;
      kind_q     <= K_INIT;
      dly_q      <= '0;
      armed_q    <= 1'b0;
      init_idx_q <= '0;
      idx_q      <= '0;
      rs_q       <= 1'b0;
      data_q     <= '0;
      e_q        <= 1'b0;
      addr_q     <= BASE_A;
      fd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      kind_q     <= kind_d;
      dly_q      <= dly_d;
      armed_q    <= armed_d;
      init_idx_q <= init_idx_d;
      idx_q      <= idx_d;
      rs_q       <= rs_d;
      data_q     <= data_d;
      e_q        <= e_d;
      addr_q     <= addr_d;
      fd_q       <= fd_d;
    end
  end

  // Next-state logic: sequencing, transfer timing and output values.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    kind_d     = kind_q;
    dly_d      = dly_q;
    armed_d    = armed_q;
    init_idx_d = init_idx_q;
    idx_d      = idx_q;
    rs_d       = rs_q;
    data_d     = data_q;
    e_d        = e_q;
    fd_d       = 1'b0;

    case (state_q)
      S_PWR_WAIT: begin
        // First cycle after reset loads the counter, then it counts down.
        if (!armed_q) begin
          dly_d   = DLY_PWR;
          armed_d = 1'b1;
        end else if (dly_q == '0) begin
          init_idx_d = '0;
          state_d    = S_INIT;
        end else begin
          dly_d = dly_q - 24'd1;
        end
      end
      S_INIT: begin
        rs_d    = 1'b0;
        data_d  = init_cmd(init_idx_q);
        kind_d  = K_INIT;
        phase_d = PH_SETUP;
        state_d = S_XFER;
      end
      S_SET_LINE: begin
        rs_d    = 1'b0;
        data_d  = idx_q[4] ? 8'hC0 : 8'h80;
        kind_d  = K_LINE;
        phase_d = PH_SETUP;
        state_d = S_XFER;
      end
      S_FETCH: begin
        // A RAM write in this cycle suppresses the read, so try again.
        if (!bus.ramWEn) state_d = S_LATCH;
      end
      S_LATCH: begin
        rs_d    = 1'b1;
        data_d  = sanitize(bus.lcdDataOut[7:0]);
        kind_d  = K_DATA;
        phase_d = PH_SETUP;
        state_d = S_XFER;
      end
      S_XFER: begin
        case (phase_q)
          PH_SETUP: begin
            e_d     = 1'b1;
            dly_d   = DLY_EHI;
            phase_d = PH_EHIGH;
          end
          PH_EHIGH: begin
            if (dly_q == '0) begin
              e_d     = 1'b0;
              phase_d = PH_HOLD;
            end else begin
              dly_d = dly_q - 24'd1;
            end
          end
          PH_HOLD: begin
            // Clear-display is the only slow command.
            dly_d   = (!rs_q && data_q == 8'h01) ? DLY_CLR : DLY_STD;
            phase_d = PH_WAIT;
          end
          PH_WAIT: begin
            if (dly_q == '0) begin
              case (kind_q)
                K_INIT: begin
                  if (init_idx_q == 2'd3) begin
                    state_d = S_SET_LINE;
                  end else begin
                    init_idx_d = init_idx_q + 2'd1;
                    state_d    = S_INIT;
                  end
                end
                K_LINE:  state_d = S_FETCH;
                default: state_d = S_NEXT;
              endcase
            end else begin
              dly_d = dly_q - 24'd1;
            end
          end
          default: phase_d = PH_SETUP;
        endcase
      end
      S_NEXT: begin
        idx_d = idx_q + 5'd1;
        if (idx_q == 5'd15) begin
          state_d = S_SET_LINE;
        end else if (idx_q == 5'd31) begin
          fd_d    = 1'b1;
          state_d = S_SET_LINE;
        end else begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_PWR_WAIT;
    endcase

    // The RAM address moves only when FETCH is entered, so a retried
    // fetch keeps presenting the same word.
    addr_d = addr_q;
    if (state_d == S_FETCH && state_q != S_FETCH)
      addr_d = BASE_A + ADDRESS_WIDTH'(idx_d);
  end

  assign bus.lcdOutAddr = addr_q;
  assign bus.lcd_rs     = rs_q;
  assign bus.lcd_rw     = 1'b0;
  assign bus.lcd_e      = e_q;
  assign bus.lcd_data   = data_q;
  assign bus.frame_done = fd_q;

endmodule
